// File: rtl/alu_result_reg.sv
// ALU result/flag output register with 2-entry skid buffer,
// sticky add/sub overflow flag and wrapping operation counter.
module alu_result_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] res_in,
  input  logic             co_in,
  input  logic             zero_in,
  input  logic             ovf_in,
  input  logic [2:0]       ctr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             co_out,
  output logic             zero_out,
  output logic             ovf_out,
  output logic [2:0]       ctr_out,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             zero;
    logic             ovf;
    logic [2:0]       ctr;
  } beat_t;

  beat_t m_q, m_d, s_q, s_d, in_beat;
  logic m_vld_q, m_vld_d;
  logic s_vld_q, s_vld_d;
  logic rdy_q, rdy_d;
  logic sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acc_in, acc_out, arith_op;

  assign in_beat  = {res_in, co_in, zero_in, ovf_in, ctr_in};
  assign acc_in   = in_valid & rdy_q;
  assign acc_out  = m_vld_q & out_ready;
  assign arith_op = (ctr_in == 3'b010) || (ctr_in == 3'b110);

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    unique case (1'b1)
      !m_vld_q: begin
        if (acc_in) begin
          m_d     = in_beat;
          m_vld_d = 1'b1;
        end
      end
      m_vld_q && !s_vld_q: begin
        if (acc_in && acc_out) begin
          m_d = in_beat;
        end else if (acc_in) begin
          s_d     = in_beat;
          s_vld_d = 1'b1;
        end else if (acc_out) begin
          m_vld_d = 1'b0;
        end
      end
      default: begin
        // full: ready is low, only drain from skid
        if (acc_out) begin
          m_d     = s_q;
          s_vld_d = 1'b0;
        end
      end
    endcase
    rdy_d = !(m_vld_d && s_vld_d);
  end

  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (acc_in && ovf_in && arith_op) sticky_d = 1'b1;
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, acc_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q      <= '0;
      s_q      <= '0;
      m_vld_q  <= 1'b0;
      s_vld_q  <= 1'b0;
      rdy_q    <= 1'b1;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      m_q      <= m_d;
      s_q      <= s_d;
      m_vld_q  <= m_vld_d;
      s_vld_q  <= s_vld_d;
      rdy_q    <= rdy_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = m_vld_q;
  assign res_out    = m_q.res;
  assign co_out     = m_q.co;
  assign zero_out   = m_q.zero;
  assign ovf_out    = m_q.ovf;
  assign ctr_out    = m_q.ctr;
  assign sticky_ovf = sticky_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_result_reg.sv
// Bench for alu_result_reg: vector table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_alu_result_reg;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  res_in;
  logic          co_in, zero_in, ovf_in;
  logic [2:0]    ctr_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  res_out;
  logic          co_out, zero_out, ovf_out;
  logic [2:0]    ctr_out;
  logic          clr_sticky;
  logic          sticky_ovf;
  logic [CW-1:0] op_count;

  alu_result_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .res_in(res_in), .co_in(co_in), .zero_in(zero_in),
    .ovf_in(ovf_in), .ctr_in(ctr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_out(res_out), .co_out(co_out), .zero_out(zero_out),
    .ovf_out(ovf_out), .ctr_out(ctr_out),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // fl = {co, zero, ovf, ctr}
  typedef struct packed {
    logic [W-1:0] res;
    logic [5:0]   fl;
  } mb_t;

  mb_t mq[$];
  int  m_cnt;
  bit  m_stk;
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
  endtask

  task automatic drive(logic v, logic [W-1:0] r, logic [5:0] f);
    in_valid = v;
    res_in   = r;
    {co_in, zero_in, ovf_in, ctr_in} = f;
  endtask

  // one clock; reference model advances with the same edge
  task automatic tick();
    bit  ai, ao, setv, clr;
    mb_t b;
    ai   = in_valid && (mq.size() < 2);
    ao   = out_ready && (mq.size() > 0);
    b    = '{res: res_in, fl: {co_in, zero_in, ovf_in, ctr_in}};
    setv = ai && ovf_in && (ctr_in == 3'd2 || ctr_in == 3'd6);
    clr  = clr_sticky;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_cnt = 0;
      m_stk = 0;
    end else begin
      if (ao) void'(mq.pop_front());
      if (ai) begin
        mq.push_back(b);
        m_cnt = (m_cnt + 1) % (2 ** CW);
      end
      if (clr) m_stk = 0;
      if (setv) m_stk = 1;
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".ovalid"}, 32'(out_valid), 32'(mq.size() > 0));
    chk({tag, ".iready"}, 32'(in_ready), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk({tag, ".res"}, res_out, mq[0].res);
      chk({tag, ".flags"}, 32'({co_out, zero_out, ovf_out, ctr_out}),
          32'(mq[0].fl));
    end
    chk({tag, ".sticky"}, 32'(sticky_ovf), 32'(m_stk));
    chk({tag, ".count"}, 32'(op_count), 32'(m_cnt));
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] res;
    logic [5:0]  fl;
    logic        ordy;
    logic        clr;
    logic        e_ov;
    logic [31:0] e_res;
    logic [5:0]  e_fl;
    logic        e_stk;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 32'h1,  6'b000010, 1, 0, 1, 32'h1,  6'b000010, 0, 4'd1};
    tbl[1] = '{1, 32'h2,  6'b000010, 1, 0, 1, 32'h2,  6'b000010, 0, 4'd2};
    tbl[2] = '{1, 32'h3,  6'b000010, 1, 0, 1, 32'h3,  6'b000010, 0, 4'd3};
    tbl[3] = '{0, 32'h0,  6'b000000, 1, 0, 0, 32'h0,  6'b000000, 0, 4'd3};
    tbl[4] = '{1, 32'h10, 6'b001110, 1, 0, 1, 32'h10, 6'b001110, 1, 4'd4};
    tbl[5] = '{0, 32'h0,  6'b000000, 1, 1, 0, 32'h0,  6'b000000, 0, 4'd4};
    tbl[6] = '{1, 32'h20, 6'b001000, 1, 0, 1, 32'h20, 6'b001000, 0, 4'd5};
    tbl[7] = '{1, 32'h30, 6'b001010, 1, 1, 1, 32'h30, 6'b001010, 1, 4'd6};
    tbl[8] = '{0, 32'h0,  6'b000000, 1, 1, 0, 32'h0,  6'b000000, 0, 4'd6};
    tbl[9] = '{1, 32'h0,  6'b110110, 1, 0, 1, 32'h0,  6'b110110, 0, 4'd7};

    rst = 1'b1;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b1, 32'hdead, 6'b111111);
    tick();
    tick();
    chk("rst.ovalid", 32'(out_valid), 32'd0);
    chk("rst.iready", 32'(in_ready), 32'd1);
    chk("rst.res", res_out, 32'd0);
    chk("rst.flags", 32'({co_out, zero_out, ovf_out, ctr_out}), 32'd0);
    chk("rst.sticky", 32'(sticky_ovf), 32'd0);
    chk("rst.count", 32'(op_count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].vld, tbl[i].res, tbl[i].fl);
      out_ready  = tbl[i].ordy;
      clr_sticky = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d.ovalid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d.iready", i), 32'(in_ready), 32'd1);
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d.res", i), res_out, tbl[i].e_res);
        chk($sformatf("vec%0d.flags", i),
            32'({co_out, zero_out, ovf_out, ctr_out}), 32'(tbl[i].e_fl));
      end
      chk($sformatf("vec%0d.sticky", i), 32'(sticky_ovf), 32'(tbl[i].e_stk));
      chk($sformatf("vec%0d.count", i), 32'(op_count), 32'(tbl[i].e_cnt));
    end
    clr_sticky = 1'b0;

    // backpressure: two beats absorbed, third held off
    drive(1'b0, 32'h0, 6'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 6'b0);
    tick();
    chk("bp.a.res", res_out, 32'hA);
    chk("bp.a.iready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'hB, 6'b0);
    tick();
    chk("bp.b.iready", 32'(in_ready), 32'd0);
    chk("bp.b.res", res_out, 32'hA);
    drive(1'b1, 32'hC, 6'b0);
    tick();
    chk("bp.c.iready", 32'(in_ready), 32'd0);
    chk("bp.c.res", res_out, 32'hA);
    chk("bp.c.count", 32'(op_count), 32'd9);
    out_ready = 1'b1;
    tick();
    chk("bp.drain1.res", res_out, 32'hB);
    chk("bp.drain1.ovalid", 32'(out_valid), 32'd1);
    tick();
    chk("bp.drain2.res", res_out, 32'hC);
    chk("bp.drain2.count", 32'(op_count), 32'd10);
    drive(1'b0, 32'h0, 6'b0);
    tick();
    chk("bp.empty.ovalid", 32'(out_valid), 32'd0);

    // reset while full
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 6'b0);
    tick();
    drive(1'b1, 32'h22, 6'b0);
    tick();
    chk("rm.full.iready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    drive(1'b1, 32'h99, 6'b001010);
    tick();
    chk("rm.ovalid", 32'(out_valid), 32'd0);
    chk("rm.iready", 32'(in_ready), 32'd1);
    chk("rm.count", 32'(op_count), 32'd0);
    tick();
    chk("rm.hold.ovalid", 32'(out_valid), 32'd0);
    chk("rm.hold.sticky", 32'(sticky_ovf), 32'd0);
    rst = 1'b0;
    drive(1'b1, 32'h33, 6'b0);
    tick();
    chk("rm.first.ovalid", 32'(out_valid), 32'd1);
    chk("rm.first.res", res_out, 32'h33);
    chk("rm.first.count", 32'(op_count), 32'd1);

    // counter wrap at 4 bits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'(i), 6'b0);
      tick();
    end
    chk("wrap.count", 32'(op_count), 32'd1);
    chk("wrap.res", res_out, 32'd16);

    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, 6'($urandom));
      out_ready  = $urandom_range(0, 1) == 1;
      clr_sticky = ($urandom_range(0, 7) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_result_reg.md
# alu_result_reg

Registered output stage directly downstream of the 32-bit ALU. It captures the ALU result and flags (`res`, `Co`, `zero`, `overflow`) together with the 3-bit ALU control that produced them, and presents them to the consumer (writeback/branch logic) over a valid/ready handshake. A 2-entry skid buffer sustains one beat per cycle even when the ready path is registered. The block also keeps a sticky arithmetic-overflow flag and a wrapping count of accepted operations.

## Interface
Parameters:
- `WIDTH`, 32, data width of result path
- `CNT_W`, 16, width of operation counter

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  ALU outputs valid this cycle
- `in_ready`  out  1  stage can accept a beat (registered)
- `res_in`  in  WIDTH  ALU result
- `co_in`  in  1  ALU carry-out
- `zero_in`  in  1  ALU zero flag
- `ovf_in`  in  1  ALU overflow flag
- `ctr_in`  in  3  ALU control that produced the beat
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  consumer accepts output beat
- `res_out`  out  WIDTH  registered result
- `co_out`, `zero_out`, `ovf_out`  out  1 each  registered flags
- `ctr_out`  out  3  registered ALU control
- `clr_sticky`  in  1  clears `sticky_ovf`
- `sticky_ovf`  out  1  set once any accepted add/sub overflowed
- `op_count`  out  CNT_W  number of accepted input beats, mod 2^CNT_W

## Operation
- Input accept: `acc_in = in_valid & in_ready`. Output accept: `acc_out = out_valid & out_ready`.
- Storage: main register M (drives outputs, `out_valid = M.valid`) and skid register S. Each holds {res, co, zero, ovf, ctr}.
- State (derived from valid bits): EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1). S valid with M empty is illegal.
- EMPTY: `acc_in` -> load M, go ONE.
- ONE: `acc_in & acc_out` -> load M with new beat, stay ONE. `acc_in & !acc_out` -> load S, go FULL. `!acc_in & acc_out` -> go EMPTY.
- FULL: `in_ready=0`, so no input can be accepted. `acc_out` -> M <= S, clear S, go ONE.
- `in_ready` is registered: next value is 1 unless the next state is FULL.
- Order is strictly FIFO. No beat is dropped or duplicated.
- Data fields are don't-care when the matching valid bit is 0. Implementations may hold old data.
- `sticky_ovf`: set on `acc_in` when `ovf_in=1` and `ctr_in` is 3'b010 (add) or 3'b110 (sub). Overflow on other ops is ignored. `clr_sticky` clears it. If set and clear occur in the same cycle, set wins.
- `op_count`: increments by 1 on each `acc_in`. It wraps from 2^CNT_W-1 to 0 with no saturation.

## Timing
- Reset (`rst=1` at an edge): `out_valid=0`, S invalid, `in_ready=1`, `res_out=0`, `co_out=zero_out=ovf_out=0`, `ctr_out=0`, `sticky_ovf=0`, `op_count=0`.
- While `rst` is held high, inputs are ignored and these values persist.
- Reset mid-operation discards all buffered beats. The first beat after reset release is accepted on the first edge with `rst=0`.
- Latency: a beat accepted at edge N is on the outputs with `out_valid=1` after edge N, so it is visible in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready=1` continuously.
- Stall: with `out_ready=0`, at most 2 beats are accepted. `in_ready` goes low the cycle after the second beat is accepted.
- Outputs are stable while `out_valid=1 & out_ready=0`.
- `sticky_ovf` and `op_count` update at the same edge as the accepting `acc_in`.

## Test plan
- Reset then stream: `out_ready=1`; send res 0x1, 0x2, 0x3 on consecutive cycles -> `res_out` shows 1, 2, 3 one cycle later each. `op_count=3`. `in_ready` stays 1.
- Backpressure: `out_ready=0`; offer 0xA, 0xB, 0xC continuously -> 0xA and 0xB accepted, `in_ready=0` afterwards, `res_out` held at 0xA. Raise `out_ready` -> outputs 0xA, 0xB, 0xC in order with none lost.
- Sticky: beat `ctr_in=3'b110`, `ovf_in=1` -> `sticky_ovf=1`. Beat `ctr_in=3'b000`, `ovf_in=1` -> no effect. Assert `clr_sticky` in the same cycle as an overflowing add -> `sticky_ovf` stays 1. Then `clr_sticky` alone -> 0.
- Counter wrap: with CNT_W=4, accept 17 beats -> `op_count=1`.
- Reset mid-operation: FULL with 0x11 and 0x22, assert `rst` one cycle -> `out_valid=0`, `in_ready=1`, `op_count=0`. The next beat 0x33 appears first on the output.
- Flag passthrough: beat {res=0, co=1, zero=1, ovf=0, ctr=3'b110} -> outputs match exactly one cycle later.
